cache_axi_bridge: RTL and testbench

CACHE_AXI_BRIDGE -- requirements
Module: cache_axi_bridge

---
 rtl/cache_axi_bridge_if.sv | 72 +++++++
 rtl/cache_axi_bridge.sv | 202 ++++++++++++++++++++
 tb/tb_cache_axi_bridge.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_axi_bridge_if.sv
// AXI3-style five-channel bundle between the cache bridge (master) and the memory side (slave).
interface cache_axi_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [3:0]        arid;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic [1:0]        arlock;
    logic [3:0]        arcache;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              arready;

    logic [3:0]        rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    logic [3:0]        awid;
    logic [ADDR_W-1:0] awaddr;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic [1:0]        awlock;
    logic [3:0]        awcache;
    logic [2:0]        awprot;
    logic              awvalid;
    logic              awready;

    logic [3:0]          wid;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;

    logic [3:0]        bid;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/cache_axi_bridge.sv
// Bridges icache/dcache line and single-beat traffic onto AXI: one outstanding read shared by
// both caches (dcache wins), one outstanding dcache write, reads blocked on a same-line write.
module cache_axi_bridge #(
    parameter int LINE_WORDS = 4,
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32
) (
    input  logic                         aclk,
    input  logic                         areset,
    cache_axi_bridge_if.master           axi,

    input  logic                         icache_rd_req,
    input  logic [2:0]                   icache_rd_type,
    input  logic [ADDR_W-1:0]            icache_rd_addr,
    output logic                         icache_rd_rdy,
    output logic                         icache_ret_valid,
    output logic                         icache_ret_last,
    output logic [DATA_W-1:0]            icache_ret_data,

    input  logic                         dcache_rd_req,
    input  logic [2:0]                   dcache_rd_type,
    input  logic [ADDR_W-1:0]            dcache_rd_addr,
    output logic                         dcache_rd_rdy,
    output logic                         dcache_ret_valid,
    output logic                         dcache_ret_last,
    output logic [DATA_W-1:0]            dcache_ret_data,

    input  logic                         dcache_wr_req,
    input  logic [2:0]                   dcache_wr_type,
    input  logic [ADDR_W-1:0]            dcache_wr_addr,
    input  logic [DATA_W/8-1:0]          dcache_wr_wstrb,
    input  logic [LINE_WORDS*DATA_W-1:0] dcache_wr_data,
    output logic                         dcache_wr_rdy,
    output logic                         dcache_wr_done
);
    localparam int         STRB_W    = DATA_W / 8;
    localparam int         BEAT_W    = $clog2(LINE_WORDS);
    localparam int         OFF       = $clog2(LINE_WORDS * STRB_W);
    localparam logic [2:0] FULL_SIZE = 3'($clog2(STRB_W));
    localparam logic [7:0] LINE_LEN  = 8'(LINE_WORDS - 1);
    localparam logic [2:0] T_LINE    = 3'b100;

    typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} w_state_t;

    function automatic logic [7:0] len_of(input logic [2:0] t);
        return (t == T_LINE) ? LINE_LEN : 8'd0;
    endfunction

    function automatic logic [2:0] size_of(input logic [2:0] t);
        return (t == T_LINE) ? FULL_SIZE : {1'b0, t[1:0]};
    endfunction

    r_state_t                  r_state;
    logic [ADDR_W-1:0]         rd_addr_q;
    logic [7:0]                rd_len_q;
    logic [2:0]                rd_size_q;
    logic [3:0]                arid_q;

    w_state_t                  w_state;
    logic [ADDR_W-1:0]         wr_addr_q;
    logic [STRB_W-1:0]         wr_strb_q;
    logic [LINE_WORDS*DATA_W-1:0] wr_data_q;
    logic [7:0]                wr_len_q;
    logic [2:0]                wr_size_q;
    logic                      wr_line_q;
    logic [BEAT_W-1:0]         beat;
    logic                      aw_done;
    logic                      w_done;

    logic haz_i, haz_d, i_acc, d_acc, rbeat, aw_hs, w_hs, w_last;

    // Hazard looks at the registered write state, so a write accepted this cycle cannot block a read accepted alongside it.
    assign haz_d = (w_state != W_IDLE) && (dcache_rd_addr[ADDR_W-1:OFF] == wr_addr_q[ADDR_W-1:OFF]);
    assign haz_i = (w_state != W_IDLE) && (icache_rd_addr[ADDR_W-1:OFF] == wr_addr_q[ADDR_W-1:OFF]);

    assign dcache_rd_rdy = (r_state == R_IDLE) && !haz_d;
    assign icache_rd_rdy = (r_state == R_IDLE) && !dcache_rd_req && !haz_i;
    assign d_acc         = dcache_rd_req && dcache_rd_rdy;
    assign i_acc         = icache_rd_req && icache_rd_rdy;

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state   <= R_IDLE;
            rd_addr_q <= '0;
            rd_len_q  <= '0;
            rd_size_q <= '0;
            arid_q    <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (d_acc) begin
                        rd_addr_q <= dcache_rd_addr;
                        rd_len_q  <= len_of(dcache_rd_type);
                        rd_size_q <= size_of(dcache_rd_type);
                        arid_q    <= 4'd1;
                        r_state   <= R_AR;
                    end else if (i_acc) begin
                        rd_addr_q <= icache_rd_addr;
                        rd_len_q  <= len_of(icache_rd_type);
                        rd_size_q <= size_of(icache_rd_type);
                        arid_q    <= 4'd0;
                        r_state   <= R_AR;
                    end
                end
                R_AR:    if (axi.arready) r_state <= R_DATA;
                R_DATA:  if (axi.rvalid && axi.rlast) r_state <= R_IDLE;
                default: r_state <= R_IDLE;
            endcase
        end
    end

    assign axi.arid    = arid_q;
    assign axi.araddr  = rd_addr_q;
    assign axi.arlen   = rd_len_q;
    assign axi.arsize  = rd_size_q;
    assign axi.arburst = 2'b01;
    assign axi.arlock  = 2'b00;
    assign axi.arcache = 4'd0;
    assign axi.arprot  = 3'd0;
    assign axi.arvalid = (r_state == R_AR) && !areset;
    assign axi.rready  = (r_state == R_DATA) && !areset;

    // Return routing follows the id we issued; rid is not trusted.
    assign rbeat            = axi.rvalid && axi.rready;
    assign dcache_ret_valid = rbeat && arid_q[0];
    assign icache_ret_valid = rbeat && !arid_q[0];
    assign dcache_ret_last  = dcache_ret_valid && axi.rlast;
    assign icache_ret_last  = icache_ret_valid && axi.rlast;
    assign dcache_ret_data  = axi.rdata;
    assign icache_ret_data  = axi.rdata;

    assign aw_hs  = axi.awvalid && axi.awready;
    assign w_hs   = axi.wvalid && axi.wready;
    assign w_last = ({{(8-BEAT_W){1'b0}}, beat} == wr_len_q);

    always_ff @(posedge aclk) begin
        if (areset) begin
            w_state   <= W_IDLE;
            wr_addr_q <= '0;
            wr_strb_q <= '0;
            wr_data_q <= '0;
            wr_len_q  <= '0;
            wr_size_q <= '0;
            wr_line_q <= 1'b0;
            beat      <= '0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (dcache_wr_req) begin
                        wr_addr_q <= dcache_wr_addr;
                        wr_strb_q <= dcache_wr_wstrb;
                        wr_data_q <= dcache_wr_data;
                        wr_len_q  <= len_of(dcache_wr_type);
                        wr_size_q <= size_of(dcache_wr_type);
                        wr_line_q <= (dcache_wr_type == T_LINE);
                        beat      <= '0;
                        aw_done   <= 1'b0;
                        w_done    <= 1'b0;
                        w_state   <= W_SEND;
                    end
                end
                W_SEND: begin
                    if (aw_hs) aw_done <= 1'b1;
                    if (w_hs) begin
                        beat <= beat + 1'b1;
                        if (w_last) w_done <= 1'b1;
                    end
                    if ((aw_done || aw_hs) && (w_done || (w_hs && w_last)))
                        w_state <= W_RESP;
                end
                W_RESP:  if (axi.bvalid) w_state <= W_IDLE;
                default: w_state <= W_IDLE;
            endcase
        end
    end

    assign dcache_wr_rdy  = (w_state == W_IDLE);
    assign dcache_wr_done = (w_state == W_RESP) && axi.bvalid && !areset;

    assign axi.awid    = 4'd1;
    assign axi.awaddr  = wr_addr_q;
    assign axi.awlen   = wr_len_q;
    assign axi.awsize  = wr_size_q;
    assign axi.awburst = 2'b01;
    assign axi.awlock  = 2'b00;
    assign axi.awcache = 4'd0;
    assign axi.awprot  = 3'd0;
    assign axi.awvalid = (w_state == W_SEND) && !aw_done && !areset;

    assign axi.wid    = 4'd1;
    assign axi.wdata  = wr_data_q[beat*DATA_W +: DATA_W];
    assign axi.wstrb  = wr_line_q ? {STRB_W{1'b1}} : wr_strb_q;
    assign axi.wlast  = w_last;
    assign axi.wvalid = (w_state == W_SEND) && !w_done && !areset;
    assign axi.bready = (w_state == W_RESP) && !areset;

    logic unused_resp;
    assign unused_resp = ^{axi.rid, axi.rresp, axi.bid, axi.bresp};
endmodule

// File: tb/tb_cache_axi_bridge.sv
// Directed scenario bench for cache_axi_bridge with a hand-driven AXI slave.
module tb_cache_axi_bridge;
    logic aclk = 1'b0;
    logic areset;
    always #5 aclk = ~aclk;

    cache_axi_bridge_if #(.ADDR_W(32), .DATA_W(32)) axi ();

    logic        icache_rd_req, icache_rd_rdy, icache_ret_valid, icache_ret_last;
    logic [2:0]  icache_rd_type;
    logic [31:0] icache_rd_addr, icache_ret_data;
    logic        dcache_rd_req, dcache_rd_rdy, dcache_ret_valid, dcache_ret_last;
    logic [2:0]  dcache_rd_type;
    logic [31:0] dcache_rd_addr, dcache_ret_data;
    logic        dcache_wr_req, dcache_wr_rdy, dcache_wr_done;
    logic [2:0]  dcache_wr_type;
    logic [31:0] dcache_wr_addr;
    logic [3:0]  dcache_wr_wstrb;
    logic [127:0] dcache_wr_data;

    int passed = 0;
    int total  = 0;

    cache_axi_bridge #(.LINE_WORDS(4), .DATA_W(32), .ADDR_W(32)) dut (
        .aclk(aclk), .areset(areset), .axi(axi),
        .icache_rd_req(icache_rd_req), .icache_rd_type(icache_rd_type), .icache_rd_addr(icache_rd_addr),
        .icache_rd_rdy(icache_rd_rdy), .icache_ret_valid(icache_ret_valid), .icache_ret_last(icache_ret_last),
        .icache_ret_data(icache_ret_data),
        .dcache_rd_req(dcache_rd_req), .dcache_rd_type(dcache_rd_type), .dcache_rd_addr(dcache_rd_addr),
        .dcache_rd_rdy(dcache_rd_rdy), .dcache_ret_valid(dcache_ret_valid), .dcache_ret_last(dcache_ret_last),
        .dcache_ret_data(dcache_ret_data),
        .dcache_wr_req(dcache_wr_req), .dcache_wr_type(dcache_wr_type), .dcache_wr_addr(dcache_wr_addr),
        .dcache_wr_wstrb(dcache_wr_wstrb), .dcache_wr_data(dcache_wr_data),
        .dcache_wr_rdy(dcache_wr_rdy), .dcache_wr_done(dcache_wr_done)
    );

    // Inputs change 2 time units after the rising edge; outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge aclk);
        #2;
    endtask

    task automatic test_reset();
        areset = 1'b1;
        tick();
        tick();
        #1;
        total++; if (axi.arvalid !== 1'b0) $display("FAIL rst_arvalid got %b want 0", axi.arvalid); else passed++;
        total++; if (axi.rready !== 1'b0) $display("FAIL rst_rready got %b want 0", axi.rready); else passed++;
        total++; if ({axi.awvalid, axi.wvalid, axi.bready} !== 3'b000)
            $display("FAIL rst_aw_w_b got %b want 000", {axi.awvalid, axi.wvalid, axi.bready}); else passed++;
        total++; if (dcache_wr_rdy !== 1'b1) $display("FAIL rst_wr_rdy got %b want 1", dcache_wr_rdy); else passed++;
        total++; if ({icache_rd_rdy, dcache_rd_rdy} !== 2'b11)
            $display("FAIL rst_rd_rdy got %b want 11", {icache_rd_rdy, dcache_rd_rdy}); else passed++;
        total++; if ({dcache_wr_done, icache_ret_valid, dcache_ret_valid} !== 3'b000)
            $display("FAIL rst_done_ret got %b want 000", {dcache_wr_done, icache_ret_valid, dcache_ret_valid}); else passed++;
        areset = 1'b0;
        tick();
    endtask

    task automatic test_icache_line();
        logic rv_pat [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        int beats = 0;
        icache_rd_req = 1'b1; icache_rd_type = 3'b100; icache_rd_addr = 32'h1000;
        #1;
        total++; if (icache_rd_rdy !== 1'b1) $display("FAIL il_rdy got %b want 1", icache_rd_rdy); else passed++;
        tick();
        icache_rd_req = 1'b0;
        #1;
        total++; if ({axi.arvalid, axi.araddr} !== {1'b1, 32'h1000})
            $display("FAIL il_ar got %b/%h want 1/1000", axi.arvalid, axi.araddr); else passed++;
        total++; if ({axi.arlen, axi.arsize, axi.arid, axi.arburst} !== {8'd3, 3'd2, 4'd0, 2'b01})
            $display("FAIL il_ar_fields got len %0d size %0d id %0d burst %0d", axi.arlen, axi.arsize, axi.arid, axi.arburst); else passed++;
        total++; if (icache_rd_rdy !== 1'b0) $display("FAIL il_rdy_busy got %b want 0", icache_rd_rdy); else passed++;
        tick();
        #1;
        total++; if ({axi.arvalid, axi.araddr, axi.arlen} !== {1'b1, 32'h1000, 8'd3})
            $display("FAIL il_ar_hold got %b/%h/%0d", axi.arvalid, axi.araddr, axi.arlen); else passed++;
        axi.arready = 1'b1;
        tick();
        axi.arready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            axi.rvalid = rv_pat[c];
            axi.rdata  = 32'hA000 + 32'(beats);
            axi.rlast  = rv_pat[c] && (beats == 3);
            #1;
            total++; if ({axi.rready, icache_ret_valid, dcache_ret_valid} !== {1'b1, rv_pat[c], 1'b0})
                $display("FAIL il_ret_valid c%0d got %b want 1%b0", c, {axi.rready, icache_ret_valid, dcache_ret_valid}, rv_pat[c]); else passed++;
            if (rv_pat[c]) begin
                total++; if ({icache_ret_data, icache_ret_last} !== {32'hA000 + 32'(beats), beats == 3})
                    $display("FAIL il_beat%0d got %h/%b want %h/%b", beats, icache_ret_data, icache_ret_last,
                             32'hA000 + 32'(beats), beats == 3); else passed++;
                beats++;
            end
            tick();
        end
        axi.rvalid = 1'b0; axi.rlast = 1'b0;
        #1;
        total++; if ({axi.rready, icache_rd_rdy} !== 2'b01)
            $display("FAIL il_end got rready %b rdy %b want 0 1", axi.rready, icache_rd_rdy); else passed++;
    endtask

    task automatic test_arbitration();
        tick();
        dcache_rd_req = 1'b1; dcache_rd_type = 3'b010; dcache_rd_addr = 32'h4000;
        icache_rd_req = 1'b1; icache_rd_type = 3'b100; icache_rd_addr = 32'h5000;
        #1;
        total++; if ({dcache_rd_rdy, icache_rd_rdy} !== 2'b10)
            $display("FAIL arb_rdy got %b want 10", {dcache_rd_rdy, icache_rd_rdy}); else passed++;
        tick();
        dcache_rd_req = 1'b0;
        #1;
        total++; if ({axi.arid, axi.araddr, axi.arlen, axi.arsize} !== {4'd1, 32'h4000, 8'd0, 3'd2})
            $display("FAIL arb_d_ar got id %0d addr %h len %0d size %0d", axi.arid, axi.araddr, axi.arlen, axi.arsize); else passed++;
        axi.arready = 1'b1;
        tick();
        axi.arready = 1'b0;
        axi.rvalid = 1'b1; axi.rlast = 1'b1; axi.rdata = 32'hD00D_0001; axi.rid = 4'd0;
        #1;
        total++; if ({dcache_ret_valid, dcache_ret_last, icache_ret_valid, dcache_ret_data} !== {3'b110, 32'hD00D_0001})
            $display("FAIL arb_d_ret got %b %h", {dcache_ret_valid, dcache_ret_last, icache_ret_valid}, dcache_ret_data); else passed++;
        tick();
        axi.rvalid = 1'b0; axi.rlast = 1'b0;
        #1;
        total++; if (icache_rd_rdy !== 1'b1) $display("FAIL arb_i_rdy got %b want 1", icache_rd_rdy); else passed++;
        tick();
        icache_rd_req = 1'b0;
        #1;
        total++; if ({axi.arvalid, axi.arid, axi.araddr, axi.arlen} !== {1'b1, 4'd0, 32'h5000, 8'd3})
            $display("FAIL arb_i_ar got %b id %0d addr %h len %0d", axi.arvalid, axi.arid, axi.araddr, axi.arlen); else passed++;
        axi.arready = 1'b1;
        tick();
        axi.arready = 1'b0;
        for (int b = 0; b < 4; b++) begin
            axi.rvalid = 1'b1; axi.rlast = (b == 3); axi.rdata = 32'hC0DE_0000 + 32'(b);
            tick();
        end
        axi.rvalid = 1'b0; axi.rlast = 1'b0;
        #1;
        total++; if ({axi.rready, dcache_rd_rdy} !== 2'b01)
            $display("FAIL arb_end got %b want 01", {axi.rready, dcache_rd_rdy}); else passed++;
    endtask

    task automatic test_line_write();
        logic [31:0] wd [4] = '{32'hAAAA_0000, 32'hBBBB_1111, 32'hCCCC_2222, 32'hDDDD_3333};
        tick();
        dcache_wr_req = 1'b1; dcache_wr_type = 3'b100; dcache_wr_addr = 32'h2000; dcache_wr_wstrb = 4'h0;
        dcache_wr_data = {wd[3], wd[2], wd[1], wd[0]};
        icache_rd_addr = 32'h2008;
        #1;
        total++; if ({dcache_wr_rdy, icache_rd_rdy} !== 2'b11)
            $display("FAIL lw_pre got %b want 11", {dcache_wr_rdy, icache_rd_rdy}); else passed++;
        tick();
        dcache_wr_req = 1'b0; dcache_wr_data = '0;
        #1;
        total++; if ({axi.awvalid, axi.awaddr, axi.awlen, axi.awsize, axi.awid, axi.wid, axi.awburst} !== {1'b1, 32'h2000, 8'd3, 3'd2, 4'd1, 4'd1, 2'b01})
            $display("FAIL lw_aw got %b %h len %0d size %0d id %0d", axi.awvalid, axi.awaddr, axi.awlen, axi.awsize, axi.awid); else passed++;
        total++; if ({dcache_wr_rdy, icache_rd_rdy} !== 2'b00)
            $display("FAIL lw_hazard got %b want 00", {dcache_wr_rdy, icache_rd_rdy}); else passed++;
        icache_rd_addr = 32'h3000;
        #1;
        total++; if (icache_rd_rdy !== 1'b1) $display("FAIL lw_other_line got %b want 1", icache_rd_rdy); else passed++;
        icache_rd_addr = 32'h2008;
        tick();
        for (int c = 0; c < 4; c++) begin
            axi.wready = 1'b1; axi.awready = (c == 3);
            #1;
            total++; if ({axi.wvalid, axi.wdata, axi.wlast, axi.wstrb, axi.awvalid} !== {1'b1, wd[c], c == 3, 4'hF, 1'b1})
                $display("FAIL lw_beat%0d got v %b d %h l %b s %h aw %b want d %h", c, axi.wvalid, axi.wdata, axi.wlast,
                         axi.wstrb, axi.awvalid, wd[c]); else passed++;
            tick();
        end
        axi.wready = 1'b0; axi.awready = 1'b0;
        #1;
        total++; if ({axi.awvalid, axi.wvalid, axi.bready, dcache_wr_done, icache_rd_rdy} !== 5'b00100)
            $display("FAIL lw_resp got %b want 00100", {axi.awvalid, axi.wvalid, axi.bready, dcache_wr_done, icache_rd_rdy}); else passed++;
        tick();
        axi.bvalid = 1'b1; axi.bresp = 2'b10;
        #1;
        total++; if ({dcache_wr_done, icache_rd_rdy} !== 2'b10)
            $display("FAIL lw_done got %b want 10", {dcache_wr_done, icache_rd_rdy}); else passed++;
        tick();
        axi.bvalid = 1'b0;
        #1;
        total++; if ({dcache_wr_done, dcache_wr_rdy, icache_rd_rdy, axi.bready} !== 4'b0110)
            $display("FAIL lw_after got %b want 0110", {dcache_wr_done, dcache_wr_rdy, icache_rd_rdy, axi.bready}); else passed++;
    endtask

    task automatic test_single_write();
        tick();
        dcache_wr_req = 1'b1; dcache_wr_type = 3'b000; dcache_wr_addr = 32'h2002; dcache_wr_wstrb = 4'b0100;
        dcache_wr_data = {96'h0, 32'h00AB_0000};
        tick();
        dcache_wr_req = 1'b0;
        axi.awready = 1'b1;
        #1;
        total++; if ({axi.awvalid, axi.awaddr, axi.awlen, axi.awsize} !== {1'b1, 32'h2002, 8'd0, 3'd0})
            $display("FAIL sw_aw got %b %h len %0d size %0d", axi.awvalid, axi.awaddr, axi.awlen, axi.awsize); else passed++;
        total++; if ({axi.wvalid, axi.wlast, axi.wstrb, axi.wdata} !== {2'b11, 4'b0100, 32'h00AB_0000})
            $display("FAIL sw_w got v %b l %b s %b d %h", axi.wvalid, axi.wlast, axi.wstrb, axi.wdata); else passed++;
        tick();
        axi.awready = 1'b0; axi.wready = 1'b1;
        #1;
        total++; if ({axi.awvalid, axi.wvalid, axi.wlast} !== 3'b011)
            $display("FAIL sw_w_after_aw got %b want 011", {axi.awvalid, axi.wvalid, axi.wlast}); else passed++;
        tick();
        axi.wready = 1'b0; axi.bvalid = 1'b1;
        #1;
        total++; if ({axi.wvalid, axi.bready, dcache_wr_done} !== 3'b011)
            $display("FAIL sw_done got %b want 011", {axi.wvalid, axi.bready, dcache_wr_done}); else passed++;
        tick();
        axi.bvalid = 1'b0;
    endtask

    task automatic test_concurrent();
        tick();
        dcache_wr_req = 1'b1; dcache_wr_type = 3'b010; dcache_wr_addr = 32'h8000; dcache_wr_wstrb = 4'hF;
        dcache_wr_data = {96'h0, 32'h1234_5678};
        icache_rd_req = 1'b1; icache_rd_type = 3'b010; icache_rd_addr = 32'h8004;
        #1;
        total++; if ({icache_rd_rdy, dcache_wr_rdy} !== 2'b11)
            $display("FAIL cc_rdy got %b want 11", {icache_rd_rdy, dcache_wr_rdy}); else passed++;
        tick();
        dcache_wr_req = 1'b0; icache_rd_req = 1'b0;
        axi.arready = 1'b1; axi.awready = 1'b1; axi.wready = 1'b1;
        #1;
        total++; if ({axi.arvalid, axi.araddr, axi.awvalid, axi.wvalid, axi.wdata} !== {1'b1, 32'h8004, 2'b11, 32'h1234_5678})
            $display("FAIL cc_issue got ar %b %h aw %b w %b %h", axi.arvalid, axi.araddr, axi.awvalid, axi.wvalid, axi.wdata); else passed++;
        tick();
        axi.arready = 1'b0; axi.awready = 1'b0; axi.wready = 1'b0;
        axi.rvalid = 1'b1; axi.rlast = 1'b1; axi.rdata = 32'h0BAD_F00D; axi.bvalid = 1'b1;
        #1;
        total++; if ({icache_ret_valid, icache_ret_last, icache_ret_data, dcache_wr_done} !== {2'b11, 32'h0BAD_F00D, 1'b1})
            $display("FAIL cc_finish got %b %b %h %b", icache_ret_valid, icache_ret_last, icache_ret_data, dcache_wr_done); else passed++;
        tick();
        axi.rvalid = 1'b0; axi.rlast = 1'b0; axi.bvalid = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        tick();
        icache_rd_req = 1'b1; icache_rd_type = 3'b100; icache_rd_addr = 32'h6000;
        tick();
        icache_rd_req = 1'b0; axi.arready = 1'b1;
        tick();
        axi.arready = 1'b0; axi.rvalid = 1'b1; axi.rlast = 1'b0; axi.rdata = 32'h6;
        tick();
        areset = 1'b1;
        tick();
        areset = 1'b0; axi.rvalid = 1'b0;
        #1;
        total++; if ({axi.rready, axi.arvalid, icache_rd_rdy, icache_ret_valid} !== 4'b0010)
            $display("FAIL rmb_abandon got %b want 0010", {axi.rready, axi.arvalid, icache_rd_rdy, icache_ret_valid}); else passed++;
        tick();
        dcache_rd_req = 1'b1; dcache_rd_type = 3'b010; dcache_rd_addr = 32'h7000;
        tick();
        dcache_rd_req = 1'b0; axi.arready = 1'b1;
        #1;
        total++; if ({axi.arvalid, axi.araddr, axi.arid} !== {1'b1, 32'h7000, 4'd1})
            $display("FAIL rmb_fresh_ar got %b %h %0d", axi.arvalid, axi.araddr, axi.arid); else passed++;
        tick();
        axi.arready = 1'b0; axi.rvalid = 1'b1; axi.rlast = 1'b1; axi.rdata = 32'h7777_0000;
        #1;
        total++; if ({dcache_ret_valid, dcache_ret_last, dcache_ret_data} !== {2'b11, 32'h7777_0000})
            $display("FAIL rmb_fresh_ret got %b %b %h", dcache_ret_valid, dcache_ret_last, dcache_ret_data); else passed++;
        tick();
        axi.rvalid = 1'b0; axi.rlast = 1'b0;
        #1;
        total++; if ({axi.rready, dcache_rd_rdy} !== 2'b01)
            $display("FAIL rmb_idle got %b want 01", {axi.rready, dcache_rd_rdy}); else passed++;
    endtask

    initial begin
        areset = 1'b1;
        icache_rd_req = 1'b0; icache_rd_type = 3'b0; icache_rd_addr = '0;
        dcache_rd_req = 1'b0; dcache_rd_type = 3'b0; dcache_rd_addr = '0;
        dcache_wr_req = 1'b0; dcache_wr_type = 3'b0; dcache_wr_addr = '0; dcache_wr_wstrb = '0; dcache_wr_data = '0;
        axi.arready = 1'b0; axi.awready = 1'b0; axi.wready = 1'b0;
        axi.rvalid = 1'b0; axi.rlast = 1'b0; axi.rdata = '0; axi.rid = '0; axi.rresp = '0;
        axi.bvalid = 1'b0; axi.bid = '0; axi.bresp = '0;

        test_reset();
        test_icache_line();
        test_arbitration();
        test_line_write();
        test_single_write();
        test_concurrent();
        test_reset_mid_burst();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
